// File: rtl/alu_exec_unit_pkg.sv
// Shared constants for the ALU execution unit: opcode encoding, FSM states, opcode decoder.
package alu_exec_unit_pkg;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd4,
    AluOr  = 4'd5,
    AluMul = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } alu_state_e;

  // Unsupported opcodes fall back to add.
  function automatic alu_op_e alu_decode(input logic [3:0] code);
    case (code)
      4'd1:    return AluSub;
      4'd4:    return AluAnd;
      4'd5:    return AluOr;
      4'd8:    return AluMul;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per step, full 2*WIDTH product.
module mul_shift_add #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MUL_CYCLES - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  // Start loads operands; each step adds the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
    end
  end

  // Product is exposed as the post-step value so the caller can capture it on the final edge.
  assign done_o    = step_i && (cnt_q == LastCnt);
  assign product_o = acc_d;

  // Datapath state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle add/sub/and/or plus multi-cycle unsigned multiply.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero
);

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;

  alu_op_e            op;
  logic               accept;
  logic [WIDTH-1:0]   alu_res;
  logic               mul_start;
  logic               mul_step;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  mul_shift_add #(
    .WIDTH     (WIDTH),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk_i    (clk),
    .rst_i    (reset),
    .start_i  (mul_start),
    .step_i   (mul_step),
    .a_i      (a),
    .b_i      (b),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  // Decode and single-cycle datapath.
  always_comb begin
    op     = alu_decode(alu_control);
    accept = in_valid && !flush && (state_q != StMul);
    case (op)
      AluSub:  alu_res = a - b;
      AluAnd:  alu_res = a & b;
      AluOr:   alu_res = a | b;
      default: alu_res = a + b;
    endcase
  end

  // Next state and next output values; DONE accepts a new request to allow back-to-back ops.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    hi_d      = hi_q;
    zero_d    = zero_q;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          if (op == AluMul) begin
            mul_start = 1'b1;
            state_d   = StMul;
          end else begin
            result_d = alu_res;
            hi_d     = '0;
            zero_d   = (alu_res == '0);
            state_d  = StDone;
          end
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          mul_step = 1'b1;
          if (mul_done) begin
            result_d = mul_product[WIDTH-1:0];
            hi_d     = mul_product[2*WIDTH-1:WIDTH];
            zero_d   = (mul_product[WIDTH-1:0] == '0);
            state_d  = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
    end
  end

  // A flush during DONE kills the pending pulse.
  assign out_valid = (state_q == StDone) && !flush;
  assign busy      = (state_q == StMul);
  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single-cycle ops plus multiply/flush/reset sequences.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [3:0]   alu_control;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic         zero;

  int n_vec  = 0;
  int n_fail = 0;

  alu_exec_unit #(
    .WIDTH     (W),
    .MUL_CYCLES(W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .alu_control(alu_control),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .busy       (busy),
    .out_valid  (out_valid),
    .result     (result),
    .hi         (hi),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   code;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp_res;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [W-1:0] xa,
                       input logic [W-1:0] xb);
    in_valid    = v;
    alu_control = c;
    a           = xa;
    b           = xb;
  endtask

  // Multiply with bounded wait; optional add requests are fired while busy and must be ignored.
  task automatic do_mul(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] e_res, input logic [W-1:0] e_hi, input logic e_zero,
                        input logic poke);
    int busy_cycles = 0;
    int early_valid = 0;
    drive(1'b1, 4'd8, xa, xb);
    tick();
    drive(1'b0, 4'd0, '0, '0);
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      if (out_valid) early_valid++;
      if (poke && busy_cycles >= 3 && busy_cycles <= 6) drive(1'b1, 4'd0, 32'd1, 32'd1);
      else drive(1'b0, 4'd0, '0, '0);
      tick();
    end
    drive(1'b0, 4'd0, '0, '0);
    chk({name, " busy_cycles"}, 64'(busy_cycles), 64'd32);
    chk({name, " early_valid"}, 64'(early_valid), 64'd0);
    chk({name, " out_valid"}, 64'(out_valid), 64'd1);
    chk({name, " result"}, 64'(result), 64'(e_res));
    chk({name, " hi"}, 64'(hi), 64'(e_hi));
    chk({name, " zero"}, 64'(zero), 64'(e_zero));
    tick();
    chk({name, " pulse_end"}, 64'(out_valid), 64'd0);
    chk({name, " hold"}, 64'(result), 64'(e_res));
  endtask

  initial begin
    vecs[0] = '{4'd0, 32'd5, 32'd7, 32'd12, 1'b0};
    vecs[1] = '{4'd1, 32'd9, 32'd9, 32'd0, 1'b1};
    vecs[2] = '{4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    vecs[4] = '{4'd5, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0};
    vecs[5] = '{4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1};
    vecs[6] = '{4'd2, 32'd3, 32'd4, 32'd7, 1'b0};
    vecs[7] = '{4'd15, 32'd10, 32'd20, 32'd30, 1'b0};
    vecs[8] = '{4'd4, 32'h0000_000F, 32'h0000_00F0, 32'd0, 1'b1};
    vecs[9] = '{4'd9, 32'd1, 32'd1, 32'd2, 1'b0};

    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 4'd0, '0, '0);
    tick();
    tick();
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst zero", 64'(zero), 64'd1);
    reset = 1'b0;

    // Multiplies first so the table below also shows hi being cleared.
    do_mul("mul_ffff_x2", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b1);
    do_mul("mul_max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_mul("mul_zero_lo", 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1'b1, 1'b0);

    // Back-to-back single-cycle ops: one result per cycle.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].code, vecs[i].va, vecs[i].vb);
      tick();
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d result", i), 64'(result), 64'(vecs[i].exp_res));
      chk($sformatf("vec%0d hi", i), 64'(hi), 64'd0);
      chk($sformatf("vec%0d zero", i), 64'(zero), 64'(vecs[i].exp_zero));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'd0);
    end
    drive(1'b0, 4'd0, '0, '0);
    tick();
    chk("idle out_valid", 64'(out_valid), 64'd0);
    chk("idle hold", 64'(result), 64'd2);

    // Flush mid-multiply at cycle 10.
    drive(1'b1, 4'd8, 32'd3, 32'd4);
    tick();
    drive(1'b0, 4'd0, '0, '0);
    for (int c = 1; c < 10; c++) tick();
    chk("flush pre busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (out_valid) seen++;
        tick();
      end
      chk("flush no result", 64'(seen), 64'd0);
    end
    drive(1'b1, 4'd0, 32'd2, 32'd3);
    tick();
    drive(1'b0, 4'd0, '0, '0);
    chk("post_flush add valid", 64'(out_valid), 64'd1);
    chk("post_flush add result", 64'(result), 64'd5);

    // Flush in DONE suppresses the pulse.
    drive(1'b1, 4'd0, 32'd6, 32'd6);
    tick();
    drive(1'b0, 4'd0, '0, '0);
    flush = 1'b1;
    #1;
    chk("done_flush out_valid", 64'(out_valid), 64'd0);
    tick();
    flush = 1'b0;

    // Flush and request together: request dropped.
    drive(1'b1, 4'd0, 32'd1, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 4'd0, '0, '0);
    chk("flush_win out_valid", 64'(out_valid), 64'd0);
    chk("flush_win busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-multiply, then first-edge accept.
    drive(1'b1, 4'd8, 32'd3, 32'd4);
    tick();
    drive(1'b0, 4'd0, '0, '0);
    tick();
    tick();
    reset = 1'b1;
    #2;
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst result", 64'(result), 64'd0);
    chk("arst hi", 64'(hi), 64'd0);
    chk("arst zero", 64'(zero), 64'd1);
    reset = 1'b0;
    drive(1'b1, 4'd5, 32'h0000_00F0, 32'h0000_000F);
    tick();
    drive(1'b0, 4'd0, '0, '0);
    chk("post_rst or valid", 64'(out_valid), 64'd1);
    chk("post_rst or result", 64'(result), 64'h0000_00FF);
    chk("post_rst or zero", 64'(zero), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL declare parameter WIDTH, default 32, datapath width of a, b, result, hi.
REQ-002 SHALL declare parameter MUL_CYCLES, default WIDTH, number of multiply iteration cycles.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request this cycle.
REQ-006 SHALL have port alu_control  input  4  operation code: 0 add, 1 sub, 4 and, 5 or, 8 multiply unsigned.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port flush  input  1  abort any operation in flight.
REQ-010 SHALL have port busy  output  1  unit cannot accept; drives pipeline stall.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse, result/hi/zero valid.
REQ-012 SHALL have port result  output  WIDTH  low word of result.
REQ-013 SHALL have port hi  output  WIDTH  high word of product; 0 for non-multiply ops.
REQ-014 SHALL have port zero  output  1  result == 0, valid with out_valid.

Function
REQ-015 Request SHALL be accepted when in_valid=1, busy=0, flush=0; otherwise ignored, no buffering.
REQ-016 States SHALL be IDLE, MUL, DONE.
REQ-017 IDLE + accepted code 0/1/4/5 SHALL register result next edge, go DONE; latency 1 cycle.
REQ-018 Unknown codes (2,3,6,7,9-15) SHALL execute as add.
REQ-019 Add/sub SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-020 IDLE + accepted code 8 SHALL latch operands, clear 2*WIDTH accumulator, go MUL.
REQ-021 MUL SHALL do one shift-add step per cycle over MUL_CYCLES cycles, then go DONE; latency MUL_CYCLES+1.
REQ-022 busy SHALL be 1 in MUL, 0 in IDLE and DONE.
REQ-023 DONE SHALL assert out_valid for exactly one cycle, then go IDLE.
REQ-024 A request in DONE SHALL be accepted same cycle (back-to-back, one result per cycle for single-cycle ops).
REQ-025 result/hi/zero SHALL hold their last values until the next out_valid.
REQ-026 flush in MUL SHALL return to IDLE next edge, no out_valid; flush in DONE SHALL suppress out_valid.
REQ-027 flush and in_valid in the same cycle: flush wins, request dropped.
REQ-028 Product SHALL be full 2*WIDTH unsigned: hi = upper word, result = lower word.

Reset
REQ-029 reset SHALL force IDLE immediately, asynchronously, including mid-multiply.
REQ-030 Reset values: busy=0, out_valid=0, result=0, hi=0, zero=1, accumulator and counter 0.
REQ-031 First accept SHALL be possible on the first edge after reset deassertion.

Structure
REQ-032 Shared package SHALL hold ALU code constants (ADD=0, SUB=1, AND=4, OR=5, MUL=8) and state encoding, reused by the ALU control decoder.
REQ-033 Multiply datapath (accumulator, multiplicand shifter, iteration counter) SHALL be sub-module mul_shift_add with start/done handshake; FSM and single-cycle ops stay in top.

Verification
REQ-034 Add a=5,b=7,code 0 -> next cycle out_valid=1, result=12, hi=0, zero=0, busy=0.
REQ-035 Sub a=9,b=9 then a=0,b=1 back-to-back -> results 0 (zero=1) then 0xFFFFFFFF (zero=0), consecutive cycles.
REQ-036 Mul a=0xFFFFFFFF,b=2 -> busy 32 cycles, out_valid at cycle 33, hi=1, result=0xFFFFFFFE.
REQ-037 Mul in flight, in_valid with code 0 during busy -> ignored; only the product appears.
REQ-038 Mul a=3,b=4, flush at cycle 10 -> no out_valid, busy=0 next cycle, following add executes normally.
REQ-039 Reset asserted mid-multiply -> outputs at reset values without clock edge; code 5 a=0xF0,b=0x0F after release -> result 0xFF.
